// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: watches a multiplexed common-anode 7-segment bus
// (active-low segments and digit selects) and recovers the hex nibble,
// blank, decimal-point and illegal-pattern state of every scanned digit.
// A digit is committed once its {an_n, seg_n} sample has stayed constant
// for STABLE clocks; frame_valid pulses when every digit has been committed.
module seg_scan_decoder #(
    parameter int NDIG   = 2,
    parameter int STABLE = 4,
    parameter int CW     = $clog2(STABLE + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        seg_n,
    input  logic [NDIG-1:0]   an_n,
    output logic [4*NDIG-1:0] data_out,
    output logic [NDIG-1:0]   blank,
    output logic [NDIG-1:0]   dp,
    output logic [NDIG-1:0]   err,
    output logic              frame_valid
);

    localparam int SW = NDIG + 8;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);

    // Inverse of the encoder table. Returns {err, blank, nibble}.
    function automatic logic [5:0] decode_seg(input logic [6:0] s);
        case (s)
            7'b0000001: decode_seg = {2'b00, 4'h0};
            7'b1001111: decode_seg = {2'b00, 4'h1};
            7'b0010010: decode_seg = {2'b00, 4'h2};
            7'b0000110: decode_seg = {2'b00, 4'h3};
            7'b1001100: decode_seg = {2'b00, 4'h4};
            7'b0100100: decode_seg = {2'b00, 4'h5};
            7'b0100000: decode_seg = {2'b00, 4'h6};
            7'b0001111: decode_seg = {2'b00, 4'h7};
            7'b0000000: decode_seg = {2'b00, 4'h8};
            7'b0000100: decode_seg = {2'b00, 4'h9};
            7'b0001000: decode_seg = {2'b00, 4'hA};
            7'b1100000: decode_seg = {2'b00, 4'hB};
            7'b0110001: decode_seg = {2'b00, 4'hC};
            7'b1000010: decode_seg = {2'b00, 4'hD};
            7'b0110000: decode_seg = {2'b00, 4'hE};
            7'b0111000: decode_seg = {2'b00, 4'hF};
            7'b1111111: decode_seg = {2'b01, 4'hF};
            default:    decode_seg = {2'b10, 4'h0};
        endcase
    endfunction

    logic [SW-1:0]     prev_q, prev_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NDIG-1:0]   seen_q, seen_d;
    logic [4*NDIG-1:0] data_q, data_d;
    logic [NDIG-1:0]   blank_q, blank_d;
    logic [NDIG-1:0]   dp_q, dp_d;
    logic [NDIG-1:0]   err_q, err_d;
    logic              fv_q, fv_d;

    logic [SW-1:0]   sample;
    logic [NDIG-1:0] sel;
    logic [NDIG-1:0] seen_next;
    logic            an_valid;
    logic            restart;
    logic            commit;
    logic [5:0]      dec;

    // Stability counting, commit detection, decode and frame tracking.
    always_comb begin
        sample    = {an_n, seg_n};
        sel       = ~an_n;
        an_valid  = (sel != '0) && ((sel & (sel - NDIG'(1))) == '0);
        restart   = (sample != prev_q) || (cnt_q == '0);
        prev_d    = sample;

        if (!an_valid) begin
            cnt_d = '0;
        end else if (restart) begin
            cnt_d = CW'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        // A fresh run counts as "below STABLE" so STABLE=1 commits every new sample.
        commit    = an_valid && (cnt_d == CNT_MAX) && (restart || (cnt_q < CNT_MAX));
        dec       = decode_seg(seg_n[7:1]);
        seen_next = seen_q | sel;

        data_d  = data_q;
        blank_d = blank_q;
        dp_d    = dp_q;
        err_d   = err_q;
        seen_d  = seen_q;
        fv_d    = 1'b0;

        if (commit) begin
            for (int d = 0; d < NDIG; d++) begin
                if (sel[d]) begin
                    err_d[d]   = dec[5];
                    blank_d[d] = dec[4];
                    dp_d[d]    = ~seg_n[0];
                    // Illegal patterns leave the previous nibble in place.
                    if (!dec[5]) begin
                        data_d[4*d +: 4] = dec[3:0];
                    end
                end
            end
            if (&seen_next) begin
                fv_d   = 1'b1;
                seen_d = '0;
            end else begin
                seen_d = seen_next;
            end
        end
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= '0;
            cnt_q   <= '0;
            seen_q  <= '0;
            data_q  <= '1;
            blank_q <= '1;
            dp_q    <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            data_q  <= data_d;
            blank_q <= blank_d;
            dp_q    <= dp_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
        end
    end

    assign data_out    = data_q;
    assign blank       = blank_q;
    assign dp          = dp_q;
    assign err         = err_q;
    assign frame_valid = fv_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder (NDIG=2, STABLE=4): table of hold
// segments with expected outputs queued as each is driven, plus a
// hand-written mid-run reset sequence.
module tb_seg_scan_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seg_n;
    logic [1:0] an_n;
    logic [7:0] data_out;
    logic [1:0] blank, dp, err;
    logic       frame_valid;

    int tests = 0;
    int fails = 0;

    seg_scan_decoder #(.NDIG(2), .STABLE(4)) dut (
        .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n),
        .data_out(data_out), .blank(blank), .dp(dp), .err(err),
        .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] an;
        logic [7:0] seg;
        int         n;
        logic [7:0] data;
        logic [1:0] blank;
        logic [1:0] dp;
        logic [1:0] err;
        int         pulses;
        logic       last_fv;
    } vec_t;

    vec_t vecs[28];
    vec_t exp_q[$];
    logic [6:0] pats[16];

    function automatic vec_t mk(input logic [1:0] an, input logic [7:0] seg, input int n,
                                input logic [7:0] data, input logic [1:0] bl, input logic [1:0] d,
                                input logic [1:0] e, input int p, input logic lf);
        vec_t v;
        v.an = an; v.seg = seg; v.n = n; v.data = data; v.blank = bl;
        v.dp = d; v.err = e; v.pulses = p; v.last_fv = lf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Hold one {an_n, seg_n} for n edges; count frame_valid pulses seen.
    task automatic drive(input logic [1:0] an, input logic [7:0] seg, input int n,
                         output int pulses, output logic last_fv);
        pulses  = 0;
        last_fv = 1'b0;
        for (int i = 0; i < n; i++) begin
            an_n  = an;
            seg_n = seg;
            @(posedge clk);
            #1;
            if (frame_valid) pulses++;
            last_fv = frame_valid;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   p;
        logic lf;
        vec_t e;

        pats = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

        vecs[0]  = mk(2'b10, 8'h0D, 4,  8'hF3, 2'b10, 2'b00, 2'b00, 0, 1'b0);
        vecs[1]  = mk(2'b01, 8'h25, 4,  8'h23, 2'b00, 2'b00, 2'b00, 1, 1'b1);
        vecs[2]  = mk(2'b10, 8'h99, 3,  8'h23, 2'b00, 2'b00, 2'b00, 0, 1'b0);
        vecs[3]  = mk(2'b10, 8'h49, 4,  8'h25, 2'b00, 2'b00, 2'b00, 0, 1'b0);
        vecs[4]  = mk(2'b10, 8'hFF, 4,  8'h2F, 2'b01, 2'b00, 2'b00, 0, 1'b0);
        vecs[5]  = mk(2'b01, 8'hFF, 4,  8'hFF, 2'b11, 2'b00, 2'b00, 1, 1'b1);
        vecs[6]  = mk(2'b10, 8'h9F, 4,  8'hF1, 2'b10, 2'b00, 2'b00, 0, 1'b0);
        vecs[7]  = mk(2'b10, 8'h7F, 4,  8'hF1, 2'b10, 2'b00, 2'b01, 0, 1'b0);
        vecs[8]  = mk(2'b10, 8'h08, 4,  8'hF9, 2'b10, 2'b01, 2'b00, 0, 1'b0);
        vecs[9]  = mk(2'b00, 8'h25, 10, 8'hF9, 2'b10, 2'b01, 2'b00, 0, 1'b0);
        vecs[10] = mk(2'b11, 8'h25, 10, 8'hF9, 2'b10, 2'b01, 2'b00, 0, 1'b0);
        vecs[11] = mk(2'b01, 8'h9F, 9,  8'h19, 2'b00, 2'b01, 2'b00, 1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] nib;
            nib = 4'(i);
            vecs[12+i] = mk(2'b10, {pats[i], nib[0]}, 4, {4'h1, nib}, 2'b00,
                            {1'b0, ~nib[0]}, 2'b00, 0, 1'b0);
        end

        an_n  = 2'b11;
        seg_n = 8'hFF;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_data",  data_out, 8'hFF);
        check("reset_blank", blank, 2'b11);
        check("reset_dp",    dp, 2'b00);
        check("reset_err",   err, 2'b00);
        check("reset_fv",    frame_valid, 1'b0);
        rst = 1'b0;

        for (int v = 0; v < 28; v++) begin
            exp_q.push_back(vecs[v]);
            drive(vecs[v].an, vecs[v].seg, vecs[v].n, p, lf);
            e = exp_q.pop_front();
            check($sformatf("v%0d_data", v),    data_out, e.data);
            check($sformatf("v%0d_blank", v),   blank, e.blank);
            check($sformatf("v%0d_dp", v),      dp, e.dp);
            check($sformatf("v%0d_err", v),     err, e.err);
            check($sformatf("v%0d_pulses", v),  p, e.pulses);
            check($sformatf("v%0d_last_fv", v), lf, e.last_fv);
        end

        // Mid-run reset discards a partial frame and a partial count.
        drive(2'b10, 8'h0D, 4, p, lf);
        check("pre_rst_data", data_out, 8'h13);
        check("pre_rst_pulses", p, 0);
        drive(2'b01, 8'h25, 2, p, lf);
        check("partial_data", data_out, 8'h13);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_data",  data_out, 8'hFF);
        check("midrst_blank", blank, 2'b11);
        check("midrst_dp",    dp, 2'b00);
        check("midrst_err",   err, 2'b00);
        check("midrst_fv",    frame_valid, 1'b0);
        drive(2'b01, 8'h25, 3, p, lf);
        check("post_rst_3_data", data_out, 8'hFF);
        check("post_rst_3_pulses", p, 0);
        drive(2'b01, 8'h25, 1, p, lf);
        check("post_rst_4_data", data_out, 8'h2F);
        check("post_rst_4_blank", blank, 2'b01);
        check("post_rst_4_fv", lf, 1'b0);
        drive(2'b01, 8'h25, 3, p, lf);
        check("post_rst_hold_pulses", p, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
